// File: rtl/axi_cache_pkg.sv
// rtl/axi_cache_pkg.sv - shared AXI cache types: burst kinds, response codes, splitter states
package axi_cache_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BURST  = 2'b01,
    ST_WAIT_B = 2'b10,
    ST_RESP   = 2'b11
  } splitter_state_t;

endpackage

// File: rtl/axi_write_splitter_if.sv
// rtl/axi_write_splitter_if.sv - client command/data/response and AXI AW/W/B signals of the splitter
interface axi_write_splitter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [ID_WIDTH-1:0]     cmd_id;
  logic [7:0]              cmd_len;
  logic [2:0]              cmd_size;
  logic [1:0]              cmd_burst;
  logic                    dat_valid;
  logic                    dat_ready;
  logic [DATA_WIDTH-1:0]   dat_wdata;
  logic [DATA_WIDTH/8-1:0] dat_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_resp;
  logic [ID_WIDTH-1:0]     rsp_id;
  logic                    m_awvalid;
  logic                    m_awready;
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [ID_WIDTH-1:0]     m_awid;
  logic [7:0]              m_awlen;
  logic [2:0]              m_awsize;
  logic [1:0]              m_awburst;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wlast;
  logic                    m_bvalid;
  logic                    m_bready;
  logic [1:0]              m_bresp;
  logic [ID_WIDTH-1:0]     m_bid;

  // The splitter is the master: it owns AXI requests and client-side readies/responses.
  modport master (
    input  cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst,
    input  dat_valid, dat_wdata, dat_wstrb, rsp_ready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_bid,
    output cmd_ready, dat_ready, rsp_valid, rsp_resp, rsp_id,
    output m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
    output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst,
    output dat_valid, dat_wdata, dat_wstrb, rsp_ready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_bid,
    input  cmd_ready, dat_ready, rsp_valid, rsp_resp, rsp_id,
    input  m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
  );

endinterface

// File: rtl/axi_write_splitter.sv
// rtl/axi_write_splitter.sv - splits one client write command plus beat stream into AXI AW/W and returns B
module axi_write_splitter
  import axi_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_write_splitter_if.master  bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  splitter_state_t       state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [1:0]            resp_q;
  logic [7:0]            beat_cnt;
  logic                  aw_done;
  logic                  w_done;

  logic in_burst, w_open, last_beat, aw_hs, w_hs;

  assign in_burst  = (state == ST_BURST);
  assign w_open    = in_burst && !w_done;
  assign last_beat = (beat_cnt == len_q);
  assign aw_hs     = bus.m_awvalid && bus.m_awready;
  assign w_hs      = bus.m_wvalid && bus.m_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      resp_q   <= '0;
      beat_cnt <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            addr_q   <= bus.cmd_addr;
            id_q     <= bus.cmd_id;
            len_q    <= bus.cmd_len;
            size_q   <= bus.cmd_size;
            burst_q  <= bus.cmd_burst;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) w_done <= 1'b1;
          end
          // Look ahead at this cycle's handshakes so both channels finishing together exits at once.
          if ((aw_done || aw_hs) && (w_done || (w_hs && last_beat))) state <= ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (bus.m_bvalid) begin
            resp_q <= (bus.m_bid == id_q) ? bus.m_bresp : RESP_SLVERR;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);

  assign bus.m_awvalid = in_burst && !aw_done;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awid    = id_q;
  assign bus.m_awlen   = len_q;
  assign bus.m_awsize  = size_q;
  assign bus.m_awburst = burst_q;

  // Beats are forwarded combinationally; payload is zeroed outside the open W window.
  assign bus.m_wvalid  = bus.dat_valid && w_open;
  assign bus.dat_ready = bus.m_wready && w_open;
  assign bus.m_wlast   = w_open && last_beat;
  assign bus.m_wdata   = w_open ? bus.dat_wdata : {DATA_WIDTH{1'b0}};
  assign bus.m_wstrb   = w_open ? bus.dat_wstrb : {STRB_WIDTH{1'b0}};

  assign bus.m_bready  = (state == ST_WAIT_B);

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_resp  = resp_q;
  assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_axi_write_splitter.sv
// tb/tb_axi_write_splitter.sv - self-checking bench for axi_write_splitter against a queue-based model
module tb_axi_write_splitter;
  import axi_cache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int NB = 1024;
  localparam int LIM = 5000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } wbeat_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } awrec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_write_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_write_splitter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Client beat source: the main sequence fills beats[], the driver consumes them on handshakes.
  wbeat_t      beats [NB];
  int          n_push = 0;
  int          n_pop = 0;
  int          drop_to = 0;
  int          rdy_mode = 0;
  int          b_req = 0;
  int          b_done = 0;
  logic [IW-1:0] b_bid = '0;
  logic [1:0]  b_resp = '0;

  wbeat_t w_obs[$];
  awrec_t aw_obs[$];
  logic   w_acc = 1'b0;
  logic   b_acc = 1'b0;

  awrec_t e_aw;
  int     e_len, e_p0, e_w0, e_a0;

  initial begin
    forever begin
      @(negedge clk);
      w_acc = 1'b0;
      b_acc = 1'b0;
      if (rst_n) begin
        if (bus.m_wvalid && bus.m_wready) begin
          w_obs.push_back('{bus.m_wdata, bus.m_wstrb, bus.m_wlast});
          w_acc = 1'b1;
        end
        if (bus.m_awvalid && bus.m_awready)
          aw_obs.push_back('{bus.m_awaddr, bus.m_awid, bus.m_awlen, bus.m_awsize, bus.m_awburst});
        if (bus.m_bvalid && bus.m_bready) b_acc = 1'b1;
      end
    end
  end

  initial begin
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = '0;
    bus.m_bid     = '0;
    bus.dat_valid = 1'b0;
    bus.dat_wdata = '0;
    bus.dat_wstrb = '0;
    forever begin
      @(posedge clk);
      #1;
      if (w_acc) n_pop++;
      if (n_pop < drop_to) n_pop = drop_to;
      if (b_acc) b_done++;
      case (rdy_mode)
        1: begin bus.m_awready = 1'b1; bus.m_wready = ~bus.m_wready; end
        2: begin bus.m_awready = 1'($urandom_range(0, 1)); bus.m_wready = 1'($urandom_range(0, 1)); end
        3: begin bus.m_awready = 1'b0; bus.m_wready = 1'b1; end
        default: begin bus.m_awready = 1'b1; bus.m_wready = 1'b1; end
      endcase
      bus.m_bvalid = (b_done != b_req);
      bus.m_bid    = b_bid;
      bus.m_bresp  = b_resp;
      if (n_pop < n_push) begin
        bus.dat_valid = 1'b1;
        bus.dat_wdata = beats[n_pop].data;
        bus.dat_wstrb = beats[n_pop].strb;
      end else begin
        bus.dat_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
    beats[n_push] = '{d, s, 1'b0};
    n_push++;
  endtask

  task automatic issue(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int len,
                       input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    int n;
    e_aw  = '{addr, id, 8'(len), size, burst};
    e_len = len;
    e_p0  = n_push;
    e_w0  = w_obs.size();
    e_a0  = aw_obs.size();
    for (int i = 0; i < nbeats; i++) push_beat({$urandom, $urandom}, SW'($urandom));
    bus.cmd_addr  = addr;
    bus.cmd_id    = id;
    bus.cmd_len   = 8'(len);
    bus.cmd_size  = size;
    bus.cmd_burst = burst;
    bus.cmd_valid = 1'b1;
    n = 0;
    tick();
    while (!bus.cmd_ready && n < LIM) begin tick(); n++; end
    check("cmd_accept_timeout", n < LIM, 1'b1);
    drive_edge();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_aw();
    int n;
    n = 0;
    while (aw_obs.size() < e_a0 + 1 && n < LIM) begin tick(); n++; end
    check("aw_timeout", n < LIM, 1'b1);
    if (aw_obs.size() >= e_a0 + 1) check("aw_fields", aw_obs[e_a0], e_aw);
  endtask

  task automatic wait_w();
    int n;
    wbeat_t exp_b;
    n = 0;
    while (w_obs.size() < e_w0 + e_len + 1 && n < LIM) begin tick(); n++; end
    check("w_timeout", n < LIM, 1'b1);
    for (int i = 0; i <= e_len; i++) begin
      exp_b = beats[e_p0 + i];
      exp_b.last = (i == e_len);
      if (w_obs.size() > e_w0 + i) check($sformatf("w_beat%0d", i), w_obs[e_w0 + i], exp_b);
    end
  endtask

  task automatic complete(input logic [IW-1:0] bid, input logic [1:0] bresp, input int hold);
    int n;
    logic [1:0] er;
    er = (bid == e_aw.id) ? bresp : RESP_SLVERR;
    drive_edge();
    b_bid  = bid;
    b_resp = bresp;
    b_req++;
    n = 0;
    tick();
    while (!bus.rsp_valid && n < LIM) begin tick(); n++; end
    check("rsp_timeout", n < LIM, 1'b1);
    check("rsp_resp", bus.rsp_resp, er);
    check("rsp_id", bus.rsp_id, e_aw.id);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rsp_hold", {bus.rsp_valid, bus.rsp_resp, bus.rsp_id}, {1'b1, er, e_aw.id});
    end
    check("beats_taken", n_pop - e_p0, e_len + 1);
    check("w_count", w_obs.size() - e_w0, e_len + 1);
    drive_edge();
    bus.rsp_ready = 1'b1;
    tick();
    drive_edge();
    bus.rsp_ready = 1'b0;
    drop_to = n_push;
    tick();
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);
    drive_edge();
  endtask

  initial begin
    int l, ex, hold;
    logic [IW-1:0] rid, rbid;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_id    = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = '0;
    bus.cmd_burst = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.rsp_valid, bus.dat_ready}, 5'b0);
    check("rst_payload", {bus.m_awaddr, bus.m_awid, bus.m_awlen, bus.m_wdata, bus.rsp_resp}, '0);
    drive_edge();
    rst_n = 1'b1;
    drive_edge();

    // INCR len=3 size=3 at 0x1000, id 5, all readies high
    issue(32'h1000, 4'd5, 3, 3'd3, BURST_INCR, 4);
    wait_aw();
    wait_w();
    complete(4'd5, RESP_OKAY, 0);

    // Minimum-latency single beat with B already pending
    e_p0 = n_push;
    e_w0 = w_obs.size();
    push_beat(64'hDEADBEEF_CAFEF00D, 8'hFF);
    b_bid = 4'd7;
    b_resp = RESP_OKAY;
    b_req++;
    drive_edge();
    bus.cmd_addr = 32'h2000; bus.cmd_id = 4'd7; bus.cmd_len = 8'd0;
    bus.cmd_size = 3'd3; bus.cmd_burst = BURST_INCR; bus.cmd_valid = 1'b1;
    tick();
    check("lat_c0_cmd_ready", bus.cmd_ready, 1'b1);
    drive_edge();
    bus.cmd_valid = 1'b0;
    tick();
    check("lat_c1_aw_w", {bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bvalid, bus.m_bready}, 5'b11110);
    check("lat_c1_wdata", {bus.m_wdata, bus.m_wstrb}, {64'hDEADBEEF_CAFEF00D, 8'hFF});
    tick();
    check("lat_c2_bready", {bus.m_bvalid, bus.m_bready, bus.rsp_valid}, 3'b110);
    tick();
    check("lat_c3_rsp", {bus.rsp_valid, bus.rsp_resp, bus.rsp_id}, {1'b1, RESP_OKAY, 4'd7});
    drive_edge();
    bus.rsp_ready = 1'b1;
    tick();
    drive_edge();
    bus.rsp_ready = 1'b0;
    check("lat_w_count", w_obs.size() - e_w0, 1);
    drop_to = n_push;

    // AW stalled 10 cycles while all W beats complete first
    rdy_mode = 3;
    issue(32'h3000, 4'd2, 3, 3'd3, BURST_INCR, 4);
    wait_w();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("aw_stall_hold", {bus.m_awvalid, bus.m_bready, bus.m_awaddr, bus.m_awid, bus.m_awlen, bus.m_awsize, bus.m_awburst},
            {2'b10, e_aw});
    end
    drive_edge();
    rdy_mode = 0;
    wait_aw();
    tick();
    check("aw_stall_wait_b", bus.m_bready, 1'b1);
    complete(4'd2, RESP_EXOKAY, 0);

    // m_wready toggling with an excess fifth client beat
    rdy_mode = 1;
    issue(32'h4000, 4'd9, 3, 3'd3, BURST_INCR, 5);
    wait_aw();
    wait_w();
    repeat (3) tick();
    check("excess_stall", {bus.dat_valid, bus.dat_ready, bus.m_wvalid}, 3'b100);
    complete(4'd9, RESP_OKAY, 0);
    rdy_mode = 0;

    // Mismatched BID forces SLVERR, response held while rsp_ready low
    issue(32'h5000, 4'd5, 1, 3'd2, BURST_WRAP, 2);
    wait_aw();
    wait_w();
    complete(4'd3, RESP_OKAY, 4);

    // Reset mid-burst after 2 of 4 beats
    rdy_mode = 3;
    issue(32'h6000, 4'd4, 3, 3'd3, BURST_INCR, 2);
    l = 0;
    while (w_obs.size() < e_w0 + 2 && l < LIM) begin tick(); l++; end
    check("mid_rst_two_beats", w_obs.size() - e_w0, 2);
    drive_edge();
    check("pre_rst_awvalid", bus.m_awvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.rsp_valid, bus.cmd_ready}, 5'b00001);
    drop_to = n_push;
    rdy_mode = 0;
    repeat (2) drive_edge();
    rst_n = 1'b1;
    drive_edge();
    issue(32'h7000, 4'd6, 2, 3'd3, BURST_INCR, 3);
    wait_aw();
    wait_w();
    complete(4'd6, RESP_OKAY, 1);

    // Randomized commands with random readies
    rdy_mode = 2;
    for (int t = 0; t < 6; t++) begin
      l = $urandom_range(0, 15);
      ex = $urandom_range(0, 1);
      hold = $urandom_range(0, 3);
      rid = IW'($urandom);
      rbid = ($urandom_range(0, 3) == 0) ? rid + 4'd1 : rid;
      issue($urandom, rid, l, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), l + 1 + ex);
      wait_aw();
      wait_w();
      complete(rbid, 2'($urandom), hold);
    end
    rdy_mode = 0;

    // Maximum length burst
    issue(32'h8000, 4'd1, 255, 3'd3, BURST_INCR, 256);
    wait_aw();
    wait_w();
    complete(4'd1, RESP_DECERR, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_write_splitter.md
Name: axi_write_splitter

Overview:
- Master-side write-channel splitter for the AXI-MM cache.
- Accepts one merged write command (address, ID and burst attributes) plus a stream of data beats from the cache writeback/eviction logic.
- Drives separate AXI AW and W channels toward memory, generating WLAST from a beat counter.
- Collects the B response and returns it to the client. One outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width (multiple of 8)
ID_WIDTH, 4, AXI ID width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  client write command valid
cmd_ready  output  1  command accepted
cmd_addr  input  ADDR_WIDTH  burst start address
cmd_id  input  ID_WIDTH  transaction ID
cmd_len  input  8  beats minus one
cmd_size  input  3  bytes per beat, log2
cmd_burst  input  2  burst type
dat_valid  input  1  client data beat valid
dat_ready  output  1  data beat accepted
dat_wdata  input  DATA_WIDTH  beat data
dat_wstrb  input  DATA_WIDTH/8  byte strobes
rsp_valid  output  1  write response valid
rsp_ready  input  1  client accepts response
rsp_resp  output  2  response code
rsp_id  output  ID_WIDTH  response ID
m_awvalid  output  1  AXI AW valid
m_awready  input  1  AXI AW ready
m_awaddr  output  ADDR_WIDTH  AXI AWADDR
m_awid  output  ID_WIDTH  AXI AWID
m_awlen  output  8  AXI AWLEN
m_awsize  output  3  AXI AWSIZE
m_awburst  output  2  AXI AWBURST
m_wvalid  output  1  AXI W valid
m_wready  input  1  AXI W ready
m_wdata  output  DATA_WIDTH  AXI WDATA
m_wstrb  output  DATA_WIDTH/8  AXI WSTRB
m_wlast  output  1  AXI WLAST
m_bvalid  input  1  AXI B valid
m_bready  output  1  AXI B ready
m_bresp  input  2  AXI BRESP
m_bid  input  ID_WIDTH  AXI BID

Behaviour:
- Reset values:
  - state = IDLE; all command, counter and flag registers cleared.
  - All valid outputs, m_bready and dat_ready are 0; cmd_ready = 1.
  - Payload outputs are 0.
- FSM states: IDLE, BURST, WAIT_B, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register addr/id/len/size/burst, clear beat_cnt, aw_done and w_done, then go to BURST.
  - No combinational path from cmd to AXI outputs.
- BURST, AW path:
  - m_awvalid = !aw_done; AW payload driven from registers, so it is stable while stalled.
  - On m_awvalid & m_awready, set aw_done. m_awvalid never drops before the handshake.
- BURST, W path:
  - Runs concurrently with and independent of AW; W may complete before AW.
  - m_wvalid = dat_valid & !w_done; dat_ready = m_wready & !w_done.
  - m_wdata and m_wstrb pass through combinationally; zero-latency beat forwarding.
  - Client must hold dat_valid and the beat stable until dat_ready; this is a client requirement.
  - m_wlast = (beat_cnt == len_q) & !w_done.
  - On each W handshake, beat_cnt increments (8-bit). On the handshake with m_wlast, set w_done; no further dat_ready.
- BURST exit: when aw_done and w_done are both set, including when both are set in the same cycle, go to WAIT_B on the next edge.
- WAIT_B:
  - m_bready = 1.
  - On m_bvalid, capture bresp and bid, then go to RESP.
  - If bid != id_q, rsp_resp is forced to SLVERR (2'b10) and rsp_id = id_q.
  - B arriving before WAIT_B is not acknowledged (m_bready = 0) and waits.
- RESP:
  - rsp_valid = 1; rsp_resp and rsp_id are held stable.
  - On rsp_ready, go to IDLE. cmd_ready is asserted in IDLE the following cycle, so back-to-back commands see one bubble.
- Boundary conditions:
  - cmd_len = 0: a single beat with m_wlast = 1.
  - cmd_len = 255: beat_cnt reaches 255 without overflow affecting WLAST.
  - Excess client beats beyond len+1 are not accepted; they stall until the next command.
  - A reset mid-burst aborts immediately: all valids drop asynchronously, and there is no recovery of the partial AXI transaction.
- Minimum latency (all readies high): cmd accepted cycle 0; AW and first W at cycle 1; single-beat burst B accepted at cycle 2 if m_bvalid is already high; rsp_valid at cycle 3.

Decomposition:
- Shared package axi_cache_pkg holds:
  - the burst type enum (FIXED/INCR/WRAP);
  - response code constants (OKAY, EXOKAY, SLVERR, DECERR);
  - the splitter FSM state enum.
- Single module; no sub-module needed. The beat counter is inline.

Test Plan:
- INCR len=3, size=3, addr 0x1000, id 5, all readies high -> one AW with awlen=3; four W beats with wlast only on the 4th; B OKAY id 5 -> rsp_resp=00, rsp_id=5.
- len=0 single beat, data 0xDEADBEEF_CAFEF00D, wstrb 0xFF -> m_wlast=1 on that beat; m_wdata matches; one AW.
- m_awready held low 10 cycles while W beats complete -> all 4 W beats transfer first; AW payload stable throughout; FSM waits, then WAIT_B after the AW handshake.
- m_wready toggling 1010 with dat_valid held -> beat order preserved; beat_cnt only advances on handshakes; excess 5th client beat is not accepted.
- B returns bid=3 for id_q=5 with bresp=OKAY -> rsp_resp=10 (SLVERR), rsp_id=5; rsp_ready held low 4 cycles -> rsp outputs stable.
- rst_n asserted mid-burst after 2 of 4 beats -> m_awvalid, m_wvalid, m_bready, rsp_valid go 0 and cmd_ready goes 1 asynchronously; a new command afterwards completes normally.
